// File: rtl/tt_bist_harness_pkg.sv
// Shared types and helpers for the BIST harness: FSM states, the feedback
// tap table and the shift/XOR step used by both the LFSR and the MISR.
package tt_bist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   // Only these widths have a tap set defined below.
   function automatic bit width_ok(input int w);
      return (w == 8) || (w == 16) || (w == 32);
   endfunction

   // Feedback polynomial (without the implicit x^W term) per width.
   function automatic logic [31:0] tap_for_width(input int w);
      case (w)
         8:       return 32'h0000_001D;
         16:      return 32'h0000_002D;
         32:      return 32'h0000_00C5;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // One Galois step on the low w bits: shift left, fold the MSB back
   // through the taps, then XOR in the parallel data word.
   function automatic logic [31:0] step_fn(input logic [31:0] x,
                                           input logic [31:0] d,
                                           input logic [31:0] taps,
                                           input int          w);
      logic [31:0] mask;
      logic [31:0] r;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      r    = (x << 1) ^ (x[5'(w - 1)] ? taps : 32'd0) ^ d;
      return r & mask;
   endfunction

endpackage

// File: rtl/tt_bist_harness_if.sv
// Control/stimulus/response bundle between the harness and whatever drives
// it (pin wrapper or bench). clk/rst_n stay outside as plain ports.
interface tt_bist_harness_if #(
   parameter int WIDTH = 8
);
   logic             ena;
   logic             start;
   logic [WIDTH-1:0] resp_in;
   logic [WIDTH-1:0] stim_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;

   modport master (
      output ena, start, resp_in,
      input  stim_out, busy, done, pass, signature
   );

   modport slave (
      input  ena, start, resp_in,
      output stim_out, busy, done, pass, signature
   );
endinterface

// File: rtl/tt_bist_harness_lfsr_misr.sv
// Single step register shared by the stimulus LFSR (data_in tied to 0) and
// the response MISR (data_in = captured response). load wins over step.
module tt_lfsr_misr
   import tt_bist_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   // Next value: reload, advance one step, or hold.
   always_comb begin
      q_d = q_q;
      if (load)
         q_d = load_val;
      else if (step)
         q_d = WIDTH'(step_fn(32'(q_q), 32'(data_in), 32'(TAPS), WIDTH));
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/tt_bist_harness.sv
// Self-test harness: drives pseudo-random vectors from an LFSR, holds each
// for SETTLE_CYCLES, compacts responses in a MISR and flags a golden match.
module tt_bist_harness
   import tt_bist_pkg::*;
#(
   parameter int          WIDTH         = 8,
   parameter int          NUM_VECTORS   = 256,
   parameter int          SETTLE_CYCLES = 1,
   parameter int unsigned SEED          = 1,
   parameter int unsigned EXPECTED_SIG  = 0
) (
   input logic               clk,
   input logic               rst_n,
   tt_bist_harness_if.slave  bus
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("tt_bist_harness: WIDTH must be 8, 16 or 32");
   end

   localparam int VW = $clog2(NUM_VECTORS + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [WIDTH-1:0] TAPS     = WIDTH'(tap_for_width(WIDTH));
   localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
   // An all-zero LFSR would lock up, so a zero seed becomes 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
   localparam logic [WIDTH-1:0] EXP_W    = WIDTH'(EXPECTED_SIG);
   localparam logic [VW-1:0]    VLAST    = VW'(NUM_VECTORS - 1);
   localparam logic [SW-1:0]    SLAST    = SW'(SETTLE_CYCLES - 1);

   state_e          state_q, state_d;
   logic [VW-1:0]   vec_cnt_q, vec_cnt_d;
   logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            run_load, run_step;
   logic [WIDTH-1:0] lfsr, sig, sig_nxt;

   // Signature value the MISR will hold after this capture edge; used to
   // register pass in the same edge that enters DONE.
   assign sig_nxt = WIDTH'(step_fn(32'(sig), 32'(bus.resp_in), 32'(TAPS), WIDTH));

   // FSM next-state and control; everything holds while ena is low.
   always_comb begin
      state_d      = state_q;
      vec_cnt_d    = vec_cnt_q;
      settle_cnt_d = settle_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      run_load     = 1'b0;
      run_step     = 1'b0;
      if (bus.ena) begin
         unique case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  run_load     = 1'b1;
                  vec_cnt_d    = '0;
                  settle_cnt_d = '0;
                  busy_d       = 1'b1;
                  done_d       = 1'b0;
                  pass_d       = 1'b0;
                  state_d      = RUN;
               end
            end
            RUN: begin
               if (settle_cnt_q == SLAST) begin
                  // Capture edge: compact response, advance stimulus.
                  run_step     = 1'b1;
                  settle_cnt_d = '0;
                  vec_cnt_d    = vec_cnt_q + VW'(1);
                  if (vec_cnt_q == VLAST) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (sig_nxt == EXP_W);
                     state_d = DONE;
                  end
               end else begin
                  settle_cnt_d = settle_cnt_q + SW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_cnt_q    <= '0;
         settle_cnt_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_cnt_q    <= vec_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   tt_lfsr_misr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (run_load),
      .load_val (SEED_EFF),
      .step     (run_step),
      .data_in  ('0),
      .q        (lfsr)
   );

   tt_lfsr_misr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (run_load),
      .load_val ('0),
      .step     (run_step),
      .data_in  (bus.resp_in),
      .q        (sig)
   );

   assign bus.stim_out  = lfsr;
   assign bus.signature = sig;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: randomized runs against a GF(2) reference model,
// with a scoreboard queue drained by an independent monitor.
module tb_tt_bist_harness;

   localparam int         W    = 8;
   localparam int         N    = 4;
   localparam int         S    = 3;
   localparam logic [7:0] SEED = 8'h01;
   localparam logic [7:0] EXP  = 8'h6C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tt_bist_harness_if #(.WIDTH(W)) bus ();

   tt_bist_harness #(
      .WIDTH(W), .NUM_VECTORS(N), .SETTLE_CYCLES(S),
      .SEED(SEED), .EXPECTED_SIG(EXP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Response "design": a lookup table indexed by the current stimulus.
   logic [7:0] rtab [256];
   assign bus.resp_in = rtab[bus.stim_out];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] sig;
      logic [7:0] fin;
      logic       pass;
      int         lat;
      logic [7:0] seq [N];
   } exp_t;

   exp_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1, then add data.
   function automatic logic [7:0] gmul_x_add(input logic [7:0] x, input logic [7:0] d);
      int v;
      v = int'(x) * 2;
      if (v >= 256) v = (v - 256) ^ 'h1D;
      return 8'(v) ^ d;
   endfunction

   task automatic model(input int frz, output exp_t e);
      logic [7:0] x, s;
      x = SEED;
      s = 8'h00;
      for (int k = 0; k < N; k++) begin
         e.seq[k] = x;
         s = gmul_x_add(s, rtab[x]);
         x = gmul_x_add(x, 8'h00);
      end
      e.sig  = s;
      e.fin  = x;
      e.pass = (s == EXP);
      e.lat  = N * S + frz;
   endtask

   // Monitor: tracks each run from busy rising, checks on done rising.
   logic       busy_p = 1'b0, done_p = 1'b0;
   int         st_cyc = 0, bcnt = 0;
   logic [7:0] got [$];
   exp_t       me;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_p = 1'b0;
         done_p = 1'b0;
      end else begin
         if (bus.busy && !busy_p) begin
            st_cyc = cyc;
            bcnt   = 0;
            got.delete();
         end
         if (bus.busy) begin
            bcnt++;
            if (got.size() == 0 || got[$] !== bus.stim_out) got.push_back(bus.stim_out);
         end
         if (bus.done && !done_p) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got done=1 want no completion");
            end else begin
               me = sb.pop_front();
               chk("signature",  bus.signature, me.sig);
               chk("final_stim", bus.stim_out,  me.fin);
               chk("pass",       bus.pass,      me.pass);
               chk("latency",    cyc - st_cyc,  me.lat);
               chk("busy_cycles", bcnt,         me.lat);
               chk("busy_at_done", bus.busy,    0);
               chk("stim_seq_len", got.size(),  N);
               for (int k = 0; k < N && k < got.size(); k++)
                  chk($sformatf("stim_seq[%0d]", k), got[k], me.seq[k]);
            end
         end
         busy_p = bus.busy;
         done_p = bus.done;
      end
   end

   task automatic run_one(input bit frz, input int fz, input int sp);
      exp_t e;
      logic from_done;
      logic [18:0] snap;
      int act, w;
      model(frz ? 5 : 0, e);
      sb.push_back(e);
      from_done = bus.done;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (from_done) chk("restart_done_clr", bus.done, 0);
      chk("start_busy", bus.busy, 1);
      act = 0;
      w   = 0;
      while (!bus.done && w < 200) begin
         if (frz && act == fz) begin
            snap = {bus.stim_out, bus.signature, bus.busy, bus.done, bus.pass};
            bus.ena = 1'b0;
            bus.start = 1'($urandom_range(0, 1));
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("freeze_hold", {bus.stim_out, bus.signature, bus.busy, bus.done, bus.pass}, snap);
            end
            bus.ena = 1'b1;
            bus.start = 1'b0;
         end
         if (act == sp) bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         act++;
         w++;
      end
      if (!bus.done) begin
         total++; bad++;
         $display("FAIL run_timeout: got done=0 want done=1 within 200 cycles");
      end
   endtask

   initial begin
      int mode, fz, sp;
      bit frz;
      bus.ena = 1'b1;
      bus.start = 1'b0;
      for (int i = 0; i < 256; i++) rtab[i] = 8'(i);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_stim", bus.stim_out, 0);
      chk("rst_sig",  bus.signature, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pass", bus.pass, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // start while disabled is ignored
      bus.ena = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.ena = 1'b1;
      chk("ena0_start_busy", bus.busy, 0);
      chk("ena0_start_stim", bus.stim_out, 0);
      @(negedge clk);

      // reset in the middle of a run
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("midrst_busy_before", bus.busy, 1);
      chk("midrst_stim_before", bus.stim_out, SEED);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_stim", bus.stim_out, 0);
      chk("midrst_sig",  bus.signature, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      @(negedge clk);

      // runs: loopback, constant FF, loopback+freeze, then random mixes
      for (int r = 0; r < 10; r++) begin
         mode = (r == 0 || r == 2) ? 0 : (r == 1) ? 1 : int'($urandom_range(0, 2));
         if (r != 9) begin
            for (int i = 0; i < 256; i++)
               rtab[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
         end
         frz = (r == 2) || (r >= 3 && $urandom_range(0, 1) == 1);
         fz  = int'($urandom_range(0, N * S - 1));
         sp  = (r >= 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, N * S - 2)) : -1;
         run_one(frz, fz, sp);
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tt_bist_harness.md
Name: tt_bist_harness

Overview:
Parametrised on-chip self-test harness for a Tiny Tapeout user design. It generates pseudo-random stimulus for the design's dedicated inputs with an LFSR, and compacts the design's outputs into a multiple-input signature register (MISR). At the end of a run it compares the signature against an expected value. It sits between the tt_um_* top-level pins and the design under test, replacing external vector drive during bring-up.

Parameters:
WIDTH, 8, stimulus/response/signature width; supported values are 8, 16, 32.
NUM_VECTORS, 256, vectors per run; minimum 1.
SETTLE_CYCLES, 1, cycles each vector is held before its response is captured; minimum 1.
SEED, 1, initial LFSR value; a value of 0 is replaced by 1.
EXPECTED_SIG, 0, golden signature for the pass check.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ena  in  1  design-selected enable; low freezes all state
start  in  1  single-cycle run request
resp_in  in  WIDTH  response from DUT outputs
stim_out  out  WIDTH  stimulus to DUT inputs
busy  out  1  run in progress
done  out  1  run complete; held high
pass  out  1  signature == EXPECTED_SIG; valid while done=1
signature  out  WIDTH  current MISR contents

Behaviour:
- Reset: the synchronous reset (rst_n=0 at a clk edge) has priority over all other inputs.
  - Applies at any time, including mid-run.
  - Result: state IDLE; stim_out=0, signature=0, busy=0, done=0, pass=0; all counters cleared.
- ena=0: all registers hold; start is ignored. Resuming with ena=1 continues exactly where the run stopped.
- Step function f(x, d) = {x[W-2:0],1'b0} ^ (x[W-1] ? TAPS : 0) ^ d.
  - TAPS: 8'h1D for W=8, 16'h002D for W=16, 32'h000000C5 for W=32.
  - LFSR update: f(lfsr, 0). MISR update: f(sig, resp_in).
- States:
  - IDLE: busy=0, done=0. An edge with start=1 and ena=1 loads stim_out=SEED, signature=0, vec_cnt=0, settle_cnt=0, and moves to RUN.
  - RUN: busy=1. Each edge increments settle_cnt. On the edge where settle_cnt==SETTLE_CYCLES-1:
    - signature <= f(signature, resp_in);
    - stim_out <= f(stim_out, 0);
    - settle_cnt <= 0; vec_cnt <= vec_cnt+1.
    - If vec_cnt==NUM_VECTORS-1, go to DONE instead. On this transition stim_out still advances.
  - DONE: busy=0, done=1, pass registered on entry. signature is held. start=1 restarts the run exactly as from IDLE, and done/pass drop on that edge.
- start during RUN is ignored.
- Latency: done rises NUM_VECTORS*SETTLE_CYCLES edges after the edge that accepted start.
- resp_in is sampled only on capture edges and must be stable for the preceding SETTLE_CYCLES-1 cycles.
- Counter widths: $clog2(NUM_VECTORS+1) and $clog2(SETTLE_CYCLES+1). No wrap within a run.

Decomposition:
- Package tt_bist_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function tap_for_width(W) returning TAPS;
  - a compile-time check that WIDTH is in {8,16,32}.
- Sub-module tt_lfsr_misr implements one step register:
  - parameters WIDTH, TAPS;
  - ports clk, rst_n, load, load_val, step, data_in, q.
- tt_lfsr_misr is instantiated twice:
  - as the LFSR, with data_in=0;
  - as the MISR, with data_in=resp_in.

Test Plan:
1. Reset mid-run: WIDTH=8, NUM_VECTORS=4, SETTLE_CYCLES=1, start, then rst_n=0 at cycle 2 -> next edge gives stim_out=0, signature=0, busy=0, done=0.
2. Loopback: WIDTH=8, SEED=1, NUM_VECTORS=4, SETTLE_CYCLES=1, resp_in=stim_out -> stim_out sequence 01,02,04,08, then 10. Final signature=8'h00; done=1 and pass=1 with EXPECTED_SIG=0.
3. Constant response: same configuration, resp_in=8'hFF -> signature sequence FF,1C,C7,6C. Final signature 8'h6C; pass=0 with EXPECTED_SIG=0, pass=1 with EXPECTED_SIG=8'h6C.
4. Settle timing: SETTLE_CYCLES=3, NUM_VECTORS=4 -> stim_out changes every 3 cycles. done rises exactly 12 edges after the start edge, and busy is high for exactly those 12 cycles.
5. ena freeze: loopback run with ena=0 for 5 cycles mid-run -> all outputs held throughout. Final signature and completion edge are shifted by exactly 5 cycles.
6. Restart and ignored start: start pulse during RUN changes nothing. start in DONE clears done on the next edge and reproduces the identical signature.
